// File: rtl/aximm_gen_pkg.sv
// Shared types and AXI constants for the user-side AXI-MM traffic generator and checker.
package aximm_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_FIN
  } wr_state_e;

  localparam logic [2:0] AXSIZE_16B   = 3'b100;
  localparam logic [1:0] AXBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [7:0] PATTERN_TAG  = 8'hA5;

endpackage

// File: rtl/aximm_wr_pattern.sv
// Deterministic beat payload: lane k = {burst, beat, k, tag}; purely combinational, no flow control.
module aximm_wr_pattern
  import aximm_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic [7:0]            burst_idx,
  input  logic [7:0]            beat_idx,
  output logic [DATA_WIDTH-1:0] pat_dat
);

  always_comb begin
    pat_dat = '0;
    for (int k = 0; k < DATA_WIDTH / 32; k++) begin
      pat_dat[32*k +: 32] = {burst_idx, beat_idx, 8'(k), PATTERN_TAG};
    end
  end

endmodule

// File: rtl/aximm_user_wr_gen.sv
// AXI4 write generator: sequential INCR bursts (AW, then W, then B), one burst in flight.
// Latency: start->AW 1 cycle, each handshake->next phase 1 cycle; every phase holds its payload under back-pressure.
module aximm_user_wr_gen
  import aximm_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  input  logic                    start,
  input  logic [7:0]              num_bursts,
  input  logic [7:0]              burst_len,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic [ID_WIDTH-1:0]     user_awid,
  output logic [2:0]              user_awsize,
  output logic [7:0]              user_awlen,
  output logic [1:0]              user_awburst,
  output logic [ADDR_WIDTH-1:0]   user_awaddr,
  output logic                    user_awvalid,
  input  logic                    user_awready,
  output logic [ID_WIDTH-1:0]     user_wid,
  output logic [DATA_WIDTH-1:0]   user_wdata,
  output logic [DATA_WIDTH/8-1:0] user_wstrb,
  output logic                    user_wlast,
  output logic                    user_wvalid,
  input  logic                    user_wready,
  input  logic [ID_WIDTH-1:0]     user_bid,
  input  logic [1:0]              user_bresp,
  input  logic                    user_bvalid,
  output logic                    user_bready,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             err_cnt
);

  wr_state_e             state;
  logic [7:0]            bursts_left;
  logic [7:0]            len_q;
  logic [7:0]            burst_idx;
  logic [7:0]            beat_idx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_step;
  logic [DATA_WIDTH-1:0] pat_dat;
  logic                  b_err;

  aximm_wr_pattern #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern (
    .burst_idx(burst_idx),
    .beat_idx (beat_idx),
    .pat_dat  (pat_dat)
  );

  // Each beat is 16 bytes, so a burst spans (len+1)*16 bytes.
  assign addr_step = ADDR_WIDTH'({len_q, 4'b0000}) + ADDR_WIDTH'(16);
  assign b_err     = (user_bresp != RESP_OKAY) || (user_bid != burst_idx[ID_WIDTH-1:0]);

  assign user_awid   = burst_idx[ID_WIDTH-1:0];
  assign user_wid    = burst_idx[ID_WIDTH-1:0];
  assign user_awlen  = len_q;
  assign user_awaddr = addr_q;
  // Payload reads as zero whenever no beat is offered.
  assign user_wdata  = user_wvalid ? pat_dat : '0;
  assign user_wstrb  = {(DATA_WIDTH/8){user_wvalid}};
  assign user_wlast  = user_wvalid && (beat_idx == len_q);

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state        <= ST_IDLE;
      bursts_left  <= '0;
      len_q        <= '0;
      burst_idx    <= '0;
      beat_idx     <= '0;
      addr_q       <= '0;
      user_awsize  <= '0;
      user_awburst <= '0;
      user_awvalid <= 1'b0;
      user_wvalid  <= 1'b0;
      user_bready  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q        <= burst_len;
            bursts_left  <= num_bursts;
            addr_q       <= base_addr;
            burst_idx    <= '0;
            beat_idx     <= '0;
            err_cnt      <= '0;
            busy         <= 1'b1;
            user_awsize  <= AXSIZE_16B;
            user_awburst <= AXBURST_INCR;
            if (num_bursts == 8'd0) begin
              state <= ST_FIN;
            end else begin
              state        <= ST_ADDR;
              user_awvalid <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (user_awready) begin
            user_awvalid <= 1'b0;
            user_wvalid  <= 1'b1;
            beat_idx     <= '0;
            state        <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (user_wready) begin
            if (beat_idx == len_q) begin
              user_wvalid <= 1'b0;
              user_bready <= 1'b1;
              state       <= ST_RESP;
            end else begin
              beat_idx <= beat_idx + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (user_bvalid) begin
            user_bready <= 1'b0;
            if (b_err && (err_cnt != 16'hFFFF)) begin
              err_cnt <= err_cnt + 16'd1;
            end
            if (bursts_left > 8'd1) begin
              bursts_left  <= bursts_left - 8'd1;
              addr_q       <= addr_q + addr_step;
              burst_idx    <= burst_idx + 8'd1;
              user_awvalid <= 1'b1;
              state        <= ST_ADDR;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          // An empty run arrives here with done low and raises it one cycle later.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
